// File: rtl/demux_pkg.sv
// Shared definitions for the 1:2 byte demux controller slice.
package demux_pkg;

    localparam int unsigned DEMUX_DATA_W = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/demux_l2_lane_reg.sv
// Per-lane output register: captures a byte and its valid when the lane is loaded.
module demux_l2_lane_reg
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = DEMUX_DATA_W
) (
    input  logic              clk_4f,
    input  logic              reset_L,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out
);

    // Valid follows the load strobe; data holds its last value between loads.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= load;
            if (load) begin
                data_out <= data_in;
            end
        end
    end

endmodule

// File: rtl/demux_l2_sel_ctrl.sv
// Lane selector FSM for the 1:2 byte demux: stripes valid bytes across two
// lanes and realigns to lane 0 after an idle timeout.
module demux_l2_sel_ctrl
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W       = DEMUX_DATA_W,
    parameter int unsigned IDLE_TIMEOUT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic              clk_4f,
    input  logic              reset_L,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              selector,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              active
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

    state_t             state;
    logic [CNT_W-1:0]   idle_cnt;
    logic               load0;
    logic               load1;

    // Selector is 0 whenever IDLE, so a new burst always lands on lane 0.
    assign load0 = valid_in && (selector == LANE0);
    assign load1 = valid_in && (selector == LANE1);

    // State is itself a register, so active is a registered output.
    assign active = (state == ST_ACTIVE);

    // FSM, striping selector and gap counter.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state    <= ST_IDLE;
            selector <= LANE0;
            idle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    if (valid_in) begin
                        selector <= LANE1;
                        state    <= ST_ACTIVE;
                    end else begin
                        selector <= LANE0;
                    end
                end
                ST_ACTIVE: begin
                    if (valid_in) begin
                        selector <= ~selector;
                        idle_cnt <= '0;
                    end else if (idle_cnt == TIMEOUT_LAST) begin
                        state    <= ST_IDLE;
                        selector <= LANE0;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    selector <= LANE0;
                    idle_cnt <= '0;
                end
            endcase
        end
    end

    demux_l2_lane_reg #(.DATA_W(DATA_W)) u_lane0 (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .load      (load0),
        .data_in   (data_in),
        .valid_out (valid_out0),
        .data_out  (data_out0)
    );

    demux_l2_lane_reg #(.DATA_W(DATA_W)) u_lane1 (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .load      (load1),
        .data_in   (data_in),
        .valid_out (valid_out1),
        .data_out  (data_out1)
    );

endmodule
